instr_fetch: RTL and testbench

- Instruction-fetch front end. Acts as the reader of the synchronous 1024x32 instruction ROM.
- Owns the program counter and drives the ROM word address, which the ROM registers with 1-cycle read latency.
- Tags each returned word with its PC and buffers it in a small FIFO. Presents {pc, instr} to decode over a valid/ready handshake.
- Sits between instruction ROM and decode stage; accepts branch/jump redirects and a halt request from the core.

---
 rtl/instr_fetch.sv | 134 +++++++++++++
 tb/tb_instr_fetch.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: instruction-fetch front end reading a synchronous 1-cycle ROM.
//   Owns the PC, issues ROM word addresses, tags returned words with their PC
//   and buffers them in a DEPTH-entry FIFO presented to decode (valid/ready).
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   rom_addr / rom_dout         ROM word address out, registered data in
//   out_valid/out_ready         decode handshake; out_instr/out_pc = FIFO head
//   redirect_valid/redirect_pc  flush and refetch from a new byte PC
//   halt_req / idle             stop issuing / halted and fully drained
// Optional (INSTR_FETCH_PERF_EN): perf_fetch_cnt, perf_stall_cnt counters.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 10,
  parameter int          DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_dout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [31:0]       out_pc,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  input  logic              halt_req,
  output logic              idle
`ifdef INSTR_FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {RUN, HALT} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_rsp_t;

  state_t            state_q, state_d;
  logic [31:0]       pc_q, inflight_pc;
  logic              inflight_v;
  logic [CW-1:0]     count;
  logic [PW-1:0]     rd_ptr, wr_ptr;
  fetch_rsp_t        mem [DEPTH];
  fetch_rsp_t        head;
  logic              pop, push, issue;
  logic [CW:0]       credit;
  logic              unused_rpc;

  assign unused_rpc = ^redirect_pc[1:0];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pop    = out_valid && out_ready;
  assign push   = inflight_v && !redirect_valid;
  // Slots already spoken for after this edge: buffered + in flight - leaving.
  // pop implies count>=1, so this never underflows.
  assign credit = {1'b0, count} + (CW+1)'(inflight_v) - (CW+1)'(pop);
  assign issue  = (state_q == RUN) && !halt_req && !redirect_valid &&
                  (credit < (CW+1)'(DEPTH));

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (halt_req)  state_d = HALT;
      HALT:    if (!halt_req) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
      inflight_v  <= 1'b0;
      inflight_pc <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      state_q    <= state_d;
      inflight_v <= issue;
      if (issue) begin
        inflight_pc <= pc_q;
        pc_q        <= pc_q + 32'd4;
      end
      if (redirect_valid) begin
        // Any same-cycle pop already happened at decode; drop everything else.
        pc_q   <= {redirect_pc[31:2], 2'b00};
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= ptr_inc(wr_ptr);
        if (pop)  rd_ptr <= ptr_inc(rd_ptr);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Payload storage needs no reset: outputs are gated by out_valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{pc: inflight_pc, instr: rom_dout};
  end

  assign head      = mem[rd_ptr];
  assign out_valid = (count != '0);
  assign out_pc    = out_valid ? head.pc    : '0;
  assign out_instr = out_valid ? head.instr : '0;
  assign rom_addr  = pc_q[ADDR_W+1:2];
  assign idle      = (state_q == HALT) && !inflight_v && (count == '0);

`ifdef INSTR_FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (issue) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if ((state_q == RUN) && !issue && !redirect_valid)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed + randomized bench for instr_fetch. The reference
// model is the delivered-stream rule: decode sees consecutive PCs from the
// last reset/redirect target, each word equal to ROM[(pc>>2) mod 1024].
module tb_instr_fetch;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  rom_addr, rom_addr1;
  logic [31:0] rom_dout = '0, rom_dout1 = '0;
  logic        out_valid, out_valid1;
  logic        out_ready;
  logic [31:0] out_instr, out_pc, out_instr1, out_pc1;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        idle, idle1;
`ifdef INSTR_FETCH_PERF_EN
  logic [31:0] pf0, ps0, pf1, ps1;
`endif

  int          n_chk = 0, n_fail = 0, pops = 0;
  logic [31:0] exp_pc = 32'h0;
  logic        prev_halt;

  always #5 clk = ~clk;

  // ROM images: word n = A000_0000 + n, registered read.
  always @(posedge clk) rom_dout  <= 32'hA000_0000 + 32'(rom_addr);
  always @(posedge clk) rom_dout1 <= 32'hA000_0000 + 32'(rom_addr1);

  instr_fetch #(.RESET_PC(32'h0), .ADDR_W(10), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr), .rom_dout(rom_dout),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt_req(halt_req), .idle(idle)
`ifdef INSTR_FETCH_PERF_EN
    , .perf_fetch_cnt(pf0), .perf_stall_cnt(ps0)
`endif
  );

  instr_fetch #(.RESET_PC(32'h0000_0FF8), .ADDR_W(10), .DEPTH(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr1), .rom_dout(rom_dout1),
    .out_valid(out_valid1), .out_ready(1'b1), .out_instr(out_instr1),
    .out_pc(out_pc1), .redirect_valid(1'b0), .redirect_pc(32'h0),
    .halt_req(1'b0), .idle(idle1)
`ifdef INSTR_FETCH_PERF_EN
    , .perf_fetch_cnt(pf1), .perf_stall_cnt(ps1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Stream model, evaluated with the inputs that apply to the coming edge.
  task automatic mon();
    if (!rst_n) exp_pc = 32'h0;
    else begin
      if (out_valid && out_ready) begin
        chk("pop_pc", out_pc, exp_pc);
        chk("pop_instr", out_instr, 32'hA000_0000 + 32'(exp_pc[11:2]));
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
    end
  endtask

  task automatic cyc();
    mon();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0;
    redirect_pc = '0; halt_req = 1'b0; prev_halt = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_instr", out_instr, 0);
    chk("rst_idle", 32'(idle), 0);
    chk("rst_addr", 32'(rom_addr), 0);
    chk("rst_addr1", 32'(rom_addr1), 32'h3FE);
`ifdef INSTR_FETCH_PERF_EN
    chk("rst_pf", pf0, 0);
    chk("rst_ps", ps0, 0);
`endif
    rst_n = 1'b1;

    // Latency and throughput.
    cyc();
    chk("lat1_valid", 32'(out_valid), 0);
    chk("lat1_addr", 32'(rom_addr), 1);
    chk("wrap_addr1", 32'(rom_addr1), 32'h3FF);
    cyc();
    chk("lat2_valid", 32'(out_valid), 1);
    chk("lat2_pc", out_pc, 0);
    chk("lat2_instr", out_instr, 32'hA000_0000);
    chk("wrap_addr2", 32'(rom_addr1), 32'h000);
    chk("wrap_pc0", out_pc1, 32'h0000_0FF8);
    chk("wrap_in0", out_instr1, 32'hA000_03FE);
`ifdef INSTR_FETCH_PERF_EN
    chk("pf_two", pf0, 2);
    chk("ps_zero", ps0, 0);
`endif
    cyc();
    chk("thr_pc", out_pc, 32'h4);
    chk("wrap_pc1", out_pc1, 32'h0000_0FFC);
    chk("wrap_in1", out_instr1, 32'hA000_03FF);
    cyc();
    chk("wrap_pc2", out_pc1, 32'h0000_1000);
    chk("wrap_in2", out_instr1, 32'hA000_0000);

    // Backpressure: exactly two buffered, issue stops, head holds.
    out_ready = 1'b0;
    repeat (5) cyc();
    chk("bp_valid", 32'(out_valid), 1);
    chk("bp_head", out_pc, 32'h8);
    chk("bp_addr", 32'(rom_addr), 32'h4);
    out_ready = 1'b1;
    repeat (2) cyc();

    // Redirect from a full FIFO, with a same-cycle pop.
    out_ready = 1'b0;
    repeat (3) cyc();
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h103;
    cyc();
    redirect_valid = 1'b0;
    chk("rd_flush", 32'(out_valid), 0);
    chk("rd_addr", 32'(rom_addr), 32'h40);
    cyc();
    chk("rd_lat1", 32'(out_valid), 0);
    cyc();
    chk("rd_valid", 32'(out_valid), 1);
    chk("rd_pc", out_pc, 32'h100);
    chk("rd_instr", out_instr, 32'hA000_0040);
    repeat (4) cyc();

    // Halt mid-stream: in-flight word still delivered, then idle.
    halt_req = 1'b1;
    cyc();
    chk("h_valid", 32'(out_valid), 1);
    chk("h_idle0", 32'(idle), 0);
    cyc();
    chk("h_drained", 32'(out_valid), 0);
    chk("h_idle1", 32'(idle), 1);
    chk("h_addr", 32'(rom_addr), 32'(exp_pc[11:2]));
    repeat (3) cyc();
    chk("h_hold", 32'(idle), 1);
    halt_req = 1'b0;
    repeat (6) cyc();

    // Redirect while halted and idle: only the PC moves.
    halt_req = 1'b1;
    repeat (4) cyc();
    chk("hr_idle0", 32'(idle), 1);
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    cyc();
    redirect_valid = 1'b0;
    chk("hr_idle1", 32'(idle), 1);
    chk("hr_addr", 32'(rom_addr), 32'h80);
    chk("hr_valid", 32'(out_valid), 0);
    halt_req = 1'b0;
    repeat (6) cyc();

    // Async reset while the FIFO is full.
    out_ready = 1'b0;
    repeat (4) cyc();
    chk("mr_full", 32'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("mr_valid", 32'(out_valid), 0);
    chk("mr_addr", 32'(rom_addr), 0);
`ifdef INSTR_FETCH_PERF_EN
    chk("mr_pf", pf0, 0);
    chk("mr_ps", ps0, 0);
`endif
    out_ready = 1'b1;
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("mr_lat1", 32'(out_valid), 0);
    cyc();
    chk("mr_pc", out_pc, 0);
    chk("mr_instr", out_instr, 32'hA000_0000);

    // Randomized traffic checked by the stream model.
    pops = 0;
    repeat (3000) begin
      out_ready = ($urandom_range(0, 9) < 7);
      prev_halt = halt_req;
      if (halt_req) halt_req = ($urandom_range(0, 7) != 0);
      else          halt_req = ($urandom_range(0, 59) == 0);
      redirect_valid = !halt_req && !prev_halt && ($urandom_range(0, 39) == 0);
      redirect_pc = $urandom;
      cyc();
    end
    redirect_valid = 1'b0; halt_req = 1'b0; out_ready = 1'b1;
    chk("rand_pops", 32'(pops > 500), 1);
    for (int i = 0; i < 10 && !out_valid; i++) cyc();
    chk("live", 32'(out_valid), 1);
    repeat (3) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
